// File: rtl/pinpon_pkg.sv
// rtl/pinpon_pkg.sv - shared state and side encodings for the ping-pong match controller
package pinpon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_SCORE      = 3'd3,
    ST_FLASH      = 3'd4,
    ST_MATCH_END  = 3'd5
  } state_t;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - registered rising-edge detector; a key held through reset yields no edge
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic edge_o
);

  logic key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= 1'b1;
    else     key_q <= key_i;
  end

  assign edge_o = key_i & ~key_q;

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - match-level controller: serve order, scoring with deuce, games, flash requests
module match_sequencer
  import pinpon_pkg::*;
#(
  parameter int WIN_POINTS   = 11,
  parameter int SERVE_ROTATE = 2,
  parameter int GAMES_TO_WIN = 2,
  parameter int SCORE_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_l,
  input  logic               key_r,
  input  logic               pt_valid,
  input  logic               pt_winner,
  input  logic               flash_done,
  output logic               rally_start,
  output logic               serve_side,
  output logic               flash_req,
  output logic               flash_side,
  output logic               flash_long,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         games_l,
  output logic [1:0]         games_r,
  output logic               match_over
);

  localparam int ROT_W = $clog2(SERVE_ROTATE + 1);
  localparam logic [SCORE_W-1:0] WIN_P   = SCORE_W'(WIN_POINTS);
  localparam logic [SCORE_W-1:0] DEUCE_P = SCORE_W'(WIN_POINTS - 1);
  localparam logic [SCORE_W-1:0] ONE_PT  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] LEAD_2  = SCORE_W'(2);
  localparam logic [ROT_W-1:0]   ROT_LAST = ROT_W'(SERVE_ROTATE - 1);
  localparam logic [ROT_W-1:0]   ROT_ONE  = ROT_W'(1);
  localparam logic [1:0]         GAMES_WIN = 2'(GAMES_TO_WIN);

  logic edge_l, edge_r;

  key_edge u_edge_l (.clk(clk), .rst(rst), .key_i(key_l), .edge_o(edge_l));
  key_edge u_edge_r (.clk(clk), .rst(rst), .key_i(key_r), .edge_o(edge_r));

  state_t             state_q;
  logic               winner_q;
  logic [ROT_W-1:0]   rot_cnt_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q;
  logic [1:0]         games_l_q, games_r_q;
  logic               serve_q, rally_start_q, flash_req_q, flash_side_q, flash_long_q, match_over_q;

  logic [SCORE_W-1:0] score_l_d, score_r_d, win_pts, lose_pts;
  logic               game_win_d, deuce, match_won;

  // Post-point scores; an equal score at or beyond WIN_POINTS-1 folds back so counters stay bounded.
  always_comb begin
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (winner_q == SIDE_R) score_r_d = score_r_q + ONE_PT;
    else                    score_l_d = score_l_q + ONE_PT;
    if (score_l_d >= DEUCE_P && score_r_d >= DEUCE_P && score_l_d == score_r_d) begin
      score_l_d = DEUCE_P;
      score_r_d = DEUCE_P;
    end
    win_pts    = (winner_q == SIDE_R) ? score_r_d : score_l_d;
    lose_pts   = (winner_q == SIDE_R) ? score_l_d : score_r_d;
    game_win_d = (win_pts >= WIN_P) && (win_pts > lose_pts) && ((win_pts - lose_pts) >= LEAD_2);
  end

  assign deuce     = (score_l_q >= DEUCE_P) && (score_r_q >= DEUCE_P);
  assign match_won = (flash_side_q == SIDE_R) ? (games_r_q == GAMES_WIN) : (games_l_q == GAMES_WIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      winner_q      <= SIDE_L;
      rot_cnt_q     <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      games_l_q     <= '0;
      games_r_q     <= '0;
      serve_q       <= SIDE_L;
      rally_start_q <= 1'b0;
      flash_req_q   <= 1'b0;
      flash_side_q  <= SIDE_L;
      flash_long_q  <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      rally_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_l || edge_r) begin
            serve_q <= edge_l ? SIDE_L : SIDE_R;
            state_q <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          if ((serve_q == SIDE_L && edge_l) || (serve_q == SIDE_R && edge_r)) begin
            rally_start_q <= 1'b1;
            state_q       <= ST_RALLY;
          end
        end
        ST_RALLY: begin
          if (pt_valid) begin
            winner_q <= pt_winner;
            state_q  <= ST_SCORE;
          end
        end
        ST_SCORE: begin
          score_l_q <= score_l_d;
          score_r_q <= score_r_d;
          if (game_win_d) begin
            if (winner_q == SIDE_R) games_r_q <= games_r_q + 2'd1;
            else                    games_l_q <= games_l_q + 2'd1;
          end
          flash_long_q <= game_win_d;
          flash_side_q <= winner_q;
          flash_req_q  <= 1'b1;
          state_q      <= ST_FLASH;
        end
        ST_FLASH: begin
          if (flash_done) begin
            flash_req_q <= 1'b0;
            if (!flash_long_q) begin
              if (deuce || rot_cnt_q == ROT_LAST) begin
                serve_q   <= ~serve_q;
                rot_cnt_q <= '0;
              end else begin
                rot_cnt_q <= rot_cnt_q + ROT_ONE;
              end
              state_q <= ST_SERVE_WAIT;
            end else if (match_won) begin
              match_over_q <= 1'b1;
              state_q      <= ST_MATCH_END;
            end else begin
              score_l_q <= '0;
              score_r_q <= '0;
              rot_cnt_q <= '0;
              serve_q   <= ~flash_side_q;
              state_q   <= ST_SERVE_WAIT;
            end
          end
        end
        ST_MATCH_END: begin
          if (edge_l || edge_r) begin
            score_l_q    <= '0;
            score_r_q    <= '0;
            games_l_q    <= '0;
            games_r_q    <= '0;
            rot_cnt_q    <= '0;
            serve_q      <= SIDE_L;
            flash_side_q <= SIDE_L;
            flash_long_q <= 1'b0;
            match_over_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rally_start = rally_start_q;
  assign serve_side  = serve_q;
  assign flash_req   = flash_req_q;
  assign flash_side  = flash_side_q;
  assign flash_long  = flash_long_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign games_l     = games_l_q;
  assign games_r     = games_r_q;
  assign match_over  = match_over_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - directed and randomized checks of match_sequencer against a game-rules model
module tb_match_sequencer;

  localparam int WP = 11;
  localparam int SR = 2;
  localparam int GW = 2;
  localparam int SW = 5;
  localparam int P_IDLE = 0, P_WAIT = 1, P_RALLY = 2, P_SCORE = 3, P_FLASH = 4, P_END = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_l = 1'b0, key_r = 1'b0, pt_valid = 1'b0, pt_winner = 1'b0, flash_done = 1'b0;
  logic rally_start, serve_side, flash_req, flash_side, flash_long, match_over;
  logic [SW-1:0] score_l, score_r;
  logic [1:0] games_l, games_r;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  match_sequencer #(.WIN_POINTS(WP), .SERVE_ROTATE(SR), .GAMES_TO_WIN(GW), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .key_l(key_l), .key_r(key_r), .pt_valid(pt_valid), .pt_winner(pt_winner),
    .flash_done(flash_done), .rally_start(rally_start), .serve_side(serve_side), .flash_req(flash_req),
    .flash_side(flash_side), .flash_long(flash_long), .score_l(score_l), .score_r(score_r),
    .games_l(games_l), .games_r(games_r), .match_over(match_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-rules model: scores per side, total points played, and the point count where deuce began.
  int m_phase, m_sc[2], m_gm[2], m_s0, m_pts, m_nd, m_win;
  int m_serve, m_fside, m_flong, m_freq, m_rs, m_over;
  int kprev[2];

  // Server after n points: one change per SR points, then one per point once deuce is reached.
  function automatic int server_after(input int s0, input int n, input int nd);
    int t;
    if (nd < 0 || n < nd) t = n / SR;
    else                  t = (nd - 1) / SR + (n - nd + 1);
    return (s0 + t) % 2;
  endfunction

  task automatic model_clear();
    m_phase = P_IDLE; m_sc = '{0, 0}; m_gm = '{0, 0}; m_s0 = 0; m_pts = 0; m_nd = -1; m_win = 0;
    m_serve = 0; m_fside = 0; m_flong = 0; m_freq = 0; m_rs = 0; m_over = 0;
  endtask

  task automatic model_step();
    int el, er, w, o;
    el = (key_l && kprev[0] == 0) ? 1 : 0;
    er = (key_r && kprev[1] == 0) ? 1 : 0;
    kprev[0] = int'(key_l);
    kprev[1] = int'(key_r);
    m_rs = 0;
    case (m_phase)
      P_IDLE: if (el + er > 0) begin
        m_s0 = el ? 0 : 1; m_serve = m_s0; m_phase = P_WAIT;
      end
      P_WAIT: if ((m_serve == 0 && el == 1) || (m_serve == 1 && er == 1)) begin
        m_rs = 1; m_phase = P_RALLY;
      end
      P_RALLY: if (pt_valid) begin
        m_win = int'(pt_winner); m_phase = P_SCORE;
      end
      P_SCORE: begin
        w = m_win; o = 1 - w;
        m_sc[w] = m_sc[w] + 1;
        m_pts = m_pts + 1;
        if (m_sc[0] >= WP - 1 && m_sc[1] >= WP - 1) begin
          if (m_sc[0] == m_sc[1]) begin m_sc[0] = WP - 1; m_sc[1] = WP - 1; end
          if (m_nd < 0) m_nd = m_pts;
        end
        m_flong = (m_sc[w] >= WP && m_sc[w] - m_sc[o] >= 2) ? 1 : 0;
        if (m_flong == 1) m_gm[w] = m_gm[w] + 1;
        m_fside = w; m_freq = 1; m_phase = P_FLASH;
      end
      P_FLASH: if (flash_done) begin
        m_freq = 0;
        if (m_flong == 0) begin
          m_serve = server_after(m_s0, m_pts, m_nd); m_phase = P_WAIT;
        end else if (m_gm[m_fside] == GW) begin
          m_over = 1; m_phase = P_END;
        end else begin
          m_sc = '{0, 0}; m_pts = 0; m_nd = -1; m_s0 = 1 - m_fside; m_serve = m_s0; m_phase = P_WAIT;
        end
      end
      P_END: if (el + er > 0) model_clear();
      default: m_phase = P_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
      kprev[0] = 1; kprev[1] = 1;
    end else begin
      model_step();
    end
    #2;
    chk("rally_start", int'(rally_start), m_rs);
    chk("serve_side", int'(serve_side), m_serve);
    chk("flash_req", int'(flash_req), m_freq);
    chk("flash_side", int'(flash_side), m_fside);
    chk("flash_long", int'(flash_long), m_flong);
    chk("score_l", int'(score_l), m_sc[0]);
    chk("score_r", int'(score_r), m_sc[1]);
    chk("games_l", int'(games_l), m_gm[0]);
    chk("games_r", int'(games_r), m_gm[1]);
    chk("match_over", int'(match_over), m_over);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input int side);
    step();
    if (side == 1) key_r = 1'b1; else key_l = 1'b1;
    step();
    key_l = 1'b0; key_r = 1'b0;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();
  endtask

  task automatic play_point(input int w, input int fd_delay, output int obs_long, output int obs_sr);
    press(m_serve);
    pt_winner = w[0]; pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    for (int i = 0; i < 8 && !flash_req; i++) step();
    chk("flash_req_rise", int'(flash_req), 1);
    obs_long = int'(flash_long);
    obs_sr = int'(score_r);
    repeat (fd_delay) step();
    flash_done = 1'b1;
    step();
    flash_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, sr;
    int exp_rot[5];
    exp_rot = '{0, 0, 1, 1, 0};

    repeat (3) step();
    chk("rst_serve_side", int'(serve_side), 0);
    chk("rst_flash_req", int'(flash_req), 0);
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_games_r", int'(games_r), 0);
    chk("rst_match_over", int'(match_over), 0);
    rst = 1'b0;
    step();

    press(1);
    chk("idle_key_r_serve", int'(serve_side), 1);
    chk("idle_no_rally_start", int'(rally_start), 0);
    press(1);
    chk("serve_rally_start", int'(rally_start), 1);
    step();
    chk("rally_start_one_cycle", int'(rally_start), 0);
    press(1);
    chk("rally_key_ignored", int'(rally_start), 0);
    flash_done = 1'b1; step(); flash_done = 1'b0; step();
    chk("rally_flash_done_ignored", int'(flash_req), 0);

    do_reset();
    press(0);
    chk("rot_serve_start", int'(serve_side), exp_rot[0]);
    for (int i = 1; i <= 4; i++) begin
      play_point(0, i % 3, fl, sr);
      chk($sformatf("rot_serve_p%0d", i), int'(serve_side), exp_rot[i]);
      chk($sformatf("rot_long_p%0d", i), fl, 0);
      chk($sformatf("rot_score_l_p%0d", i), int'(score_l), i);
    end

    for (int i = 0; i < 6; i++) play_point(0, 0, fl, sr);
    for (int i = 0; i < 10; i++) play_point(1, 1, fl, sr);
    chk("deuce_start_l", int'(score_l), 10);
    chk("deuce_start_r", int'(score_r), 10);
    play_point(1, 0, fl, sr);
    chk("adv_r", int'(score_r), 11);
    play_point(0, 2, fl, sr);
    chk("collapse_l", int'(score_l), 10);
    chk("collapse_r", int'(score_r), 10);
    play_point(1, 0, fl, sr);
    play_point(1, 1, fl, sr);
    chk("game_flash_long", fl, 1);
    chk("game_score_r_12", sr, 12);
    chk("game1_games_r", int'(games_r), 1);
    chk("game1_cleared_l", int'(score_l), 0);
    chk("game1_cleared_r", int'(score_r), 0);
    chk("game1_loser_serves", int'(serve_side), 0);

    step(); pt_winner = 1'b1; pt_valid = 1'b1; step(); pt_valid = 1'b0; step();
    chk("wait_pt_ignored_r", int'(score_r), 0);
    chk("wait_pt_ignored_req", int'(flash_req), 0);

    for (int i = 0; i < 11; i++) play_point(1, i % 2, fl, sr);
    chk("match_over_set", int'(match_over), 1);
    chk("match_games_r", int'(games_r), 2);
    press(0);
    chk("end_clear_over", int'(match_over), 0);
    chk("end_clear_games_r", int'(games_r), 0);
    chk("end_clear_score_r", int'(score_r), 0);

    step(); key_l = 1'b1; key_r = 1'b1; step(); key_l = 1'b0; key_r = 1'b0;
    chk("simul_edges_left", int'(serve_side), 0);
    press(1);
    chk("receiver_key_ignored", int'(rally_start), 0);

    press(0);
    pt_winner = 1'b1; pt_valid = 1'b1; step(); pt_valid = 1'b0;
    for (int i = 0; i < 8 && !flash_req; i++) step();
    chk("pre_reset_flash_req", int'(flash_req), 1);
    key_l = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_rst_flash_req", int'(flash_req), 0);
    chk("async_rst_score_r", int'(score_r), 0);
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    press(1);
    chk("held_key_no_edge", int'(serve_side), 1);

    do_reset();
    for (int c = 0; c < 15000; c++) begin
      step();
      key_l      = ($urandom_range(0, 3) == 0);
      key_r      = ($urandom_range(0, 3) == 0);
      pt_valid   = ($urandom_range(0, 5) == 0);
      pt_winner  = ($urandom_range(0, 1) == 1);
      flash_done = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 3999) == 0);
    end
    step();
    rst = 1'b0; key_l = 1'b0; key_r = 1'b0; pt_valid = 1'b0; flash_done = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
